// File: rtl/uart_pkg.sv
// Shared definitions for the UART MMIO bridge: register offsets, STATUS/CTRL
// bit positions, the bridge FSM state encoding and the CTRL register layout.
package uart_pkg;

   localparam logic [3:0] ADDR_DATA   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_CTRL   = 4'h8;
   localparam logic [3:0] ADDR_RSVD   = 4'hC;

   localparam int STAT_RX_VALID   = 0;
   localparam int STAT_TX_READY   = 1;
   localparam int STAT_OVERRUN    = 2;
   localparam int STAT_TX_TIMEOUT = 3;

   localparam int CTRL_RX_IE  = 2;
   localparam int CTRL_TX_IE  = 3;
   localparam int CTRL_ERR_IE = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } bridge_state_e;

   typedef struct packed {
      logic       err_ie;
      logic       tx_ie;
      logic       rx_ie;
      logic [1:0] baud_sel;
   } ctrl_reg_t;

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// CPU-side load/store bus of the UART bridge. Handshake: the master raises req
// with we/addr/wdata stable and holds them until it samples ready high; ready is
// a one-cycle strobe during which rdata and err are valid. No response without req.
interface uart_mmio_bridge_if;
   logic        req;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;

   modport master (output req, output we, output addr, output wdata,
                   input rdata, input ready, input err);
   modport slave  (input req, input we, input addr, input wdata,
                   output rdata, output ready, output err);
endinterface

// File: rtl/uart_mmio_bridge.sv
// UART MMIO register front end: DATA push/pop, STATUS, CTRL, sticky errors and
// bounded TX wait. Optional interrupt logic is enabled by UART_BRIDGE_IRQ_EN.
module uart_mmio_bridge
   import uart_pkg::*;
#(
   parameter int DataWidth     = 8,
   parameter int TimeoutCycles = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   uart_mmio_bridge_if.slave    bus,
   output logic                 tx_valid_o,
   output logic [DataWidth-1:0] tx_data_o,
   input  logic                 tx_ready_i,
   input  logic                 rx_valid_i,
   input  logic [DataWidth-1:0] rx_data_i,
   output logic                 rx_pop_o,
   input  logic                 rx_overrun_i,
   output logic [1:0]           baud_sel_o,
   output logic                 irq_o,
   output bridge_state_e        state_o
);

   localparam int CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

   bridge_state_e        state_q, state_d;
   logic                 we_q;
   logic [3:0]           addr_q;
   logic [31:0]          wdata_q;
   logic [CntWidth-1:0]  cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic [31:0]          rdata_q, rdata_d;
   ctrl_reg_t            ctrl_q, ctrl_d;
   logic                 overrun_q, timeout_q;
   logic                 timeout_set, w1c_overrun, w1c_timeout;
   logic                 addr_ok, in_access, wait_expired;
   logic [31:0]          rx_word, status_word;
   logic                 unused_wdata;

   // Decode works on the latched request so no output depends on req directly.
   assign addr_ok      = (addr_q[1:0] == 2'b00) && (addr_q != ADDR_RSVD);
   assign in_access    = (state_q == ST_ACCESS);
   assign wait_expired = (TimeoutCycles != 0) && (cnt_q == CntWidth'(TimeoutCycles - 1));

   assign tx_valid_o = in_access && we_q && addr_ok && (addr_q == ADDR_DATA);
   assign tx_data_o  = tx_valid_o ? wdata_q[DataWidth-1:0] : '0;
   assign rx_pop_o   = in_access && !we_q && addr_ok && (addr_q == ADDR_DATA) && rx_valid_i;

   assign bus.ready  = (state_q == ST_RESP);
   assign bus.err    = (state_q == ST_RESP) && err_q;
   assign bus.rdata  = rdata_q;
   assign baud_sel_o = ctrl_q.baud_sel;
   assign state_o    = state_q;
   assign unused_wdata = ^wdata_q;

   always_comb begin
      rx_word     = 32'(rx_data_i);
      rx_word[31] = ~rx_valid_i;
      status_word = '0;
      status_word[STAT_RX_VALID]   = rx_valid_i;
      status_word[STAT_TX_READY]   = tx_ready_i;
      status_word[STAT_OVERRUN]    = overrun_q;
      status_word[STAT_TX_TIMEOUT] = timeout_q;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      ctrl_d      = ctrl_q;
      timeout_set = 1'b0;
      w1c_overrun = 1'b0;
      w1c_timeout = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               state_d = ST_ACCESS;
               cnt_d   = '0;
               err_d   = 1'b0;
               rdata_d = '0;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            if (!addr_ok) begin
               err_d   = 1'b1;
               rdata_d = '0;
            end else if (we_q) begin
               unique case (addr_q)
                  ADDR_DATA: begin
                     if (!tx_ready_i) begin
                        if (wait_expired) begin
                           timeout_set = 1'b1;
                           err_d       = 1'b1;
                        end else begin
                           state_d = ST_ACCESS;
                           // A zero timeout waits forever; keep the counter parked.
                           if (TimeoutCycles != 0) cnt_d = cnt_q + CntWidth'(1);
                        end
                     end
                  end
                  ADDR_STATUS: begin
                     w1c_overrun = wdata_q[STAT_OVERRUN];
                     w1c_timeout = wdata_q[STAT_TX_TIMEOUT];
                  end
                  ADDR_CTRL: begin
                     ctrl_d.baud_sel = wdata_q[1:0];
`ifdef UART_BRIDGE_IRQ_EN
                     ctrl_d.rx_ie  = wdata_q[CTRL_RX_IE];
                     ctrl_d.tx_ie  = wdata_q[CTRL_TX_IE];
                     ctrl_d.err_ie = wdata_q[CTRL_ERR_IE];
`endif
                  end
                  default: ;
               endcase
            end else begin
               unique case (addr_q)
                  ADDR_DATA:   rdata_d = rx_word;
                  ADDR_STATUS: rdata_d = status_word;
                  ADDR_CTRL:   rdata_d = 32'(ctrl_q);
                  default:     rdata_d = '0;
               endcase
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         ctrl_q  <= ctrl_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state_q == ST_IDLE && bus.req) begin
         we_q    <= bus.we;
         addr_q  <= bus.addr;
         wdata_q <= bus.wdata;
      end
   end

   // A set arriving in the same cycle as its W1C clear wins.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         overrun_q <= rx_overrun_i | (overrun_q & ~w1c_overrun);
         timeout_q <= timeout_set  | (timeout_q & ~w1c_timeout);
      end
   end

`ifdef UART_BRIDGE_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) irq_q <= 1'b0;
      else irq_q <= (ctrl_q.rx_ie & rx_valid_i) | (ctrl_q.tx_ie & tx_ready_i) |
                    (ctrl_q.err_ie & (overrun_q | timeout_q));
   end
   assign irq_o = irq_q;
`else
   assign irq_o = 1'b0;
`endif

endmodule

// File: doc/uart_mmio_bridge.md
# uart_mmio_bridge

Memory-mapped register front end that sits directly upstream of the UART controller. It converts CPU load/store requests from the RISC-V core into transmit-FIFO pushes, receive-FIFO pops, status reads and control writes. It owns the UART control register (baud select, interrupt enables), the sticky error flags and the bounded-wait logic for pushes to a full transmit FIFO.

## Interface
Parameters:
- DataWidth, 8, UART character width; must be ≤ 30.
- TimeoutCycles, 1024, cycles a DATA write may wait on tx_ready_i before it aborts; 0 means wait forever.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  CPU request; held high until ready_o
- we_i  in  1  1 = write, 0 = read
- addr_i  in  4  byte address: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC reserved
- wdata_i  in  32  write data
- rdata_o  out  32  read data, valid while ready_o
- ready_o  out  1  one-cycle response strobe
- err_o  out  1  error response, valid while ready_o
- tx_valid_o  out  1  push request to transmit FIFO
- tx_data_o  out  DataWidth  byte to push
- tx_ready_i  in  1  transmit FIFO not full
- rx_valid_i  in  1  receive FIFO not empty
- rx_data_i  in  DataWidth  receive FIFO head
- rx_pop_o  out  1  one-cycle pop of the receive FIFO
- rx_overrun_i  in  1  pulse: receiver dropped a character
- baud_sel_o  out  2  baud rate select to the baud generator
- irq_o  out  1  level interrupt

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If req_i, latch we_i, addr_i and wdata_i, then go to ACCESS.
- ACCESS:
  - DATA write:
    - Drive tx_valid_o = 1 with tx_data_o = latched wdata[DataWidth-1:0].
    - If tx_ready_i, go to RESP (ok).
    - Otherwise increment the wait counter. At count == TimeoutCycles-1, set sticky tx_timeout and go to RESP with err.
  - DATA read:
    - Capture rdata = {~rx_valid_i, zeros, rx_data_i}, so bit 31 = empty.
    - Pulse rx_pop_o only if rx_valid_i. Go to RESP.
  - STATUS read:
    - bit0 = rx_valid_i, bit1 = tx_ready_i, bit2 = overrun, bit3 = tx_timeout; all other bits 0.
  - STATUS write: bits 2 and 3 are write-1-to-clear.
  - CTRL read/write:
    - [1:0] = baud_sel, [2] = rx_ie, [3] = tx_ie, [4] = err_ie; other bits read 0.
  - Reserved address 0xC, or addr_i[1:0] != 0:
    - No side effect; err in RESP; rdata = 0.
- RESP:
  - ready_o = 1 and err_o as decided in ACCESS. rdata_o holds the captured value.
  - Next state is IDLE.
- Sticky overrun: set by rx_overrun_i in any state. If a set and a W1C clear land in the same cycle, set wins. Same rule for tx_timeout.
- The wait counter clears on entry to ACCESS. Width is $clog2(TimeoutCycles+1), minimum 1.
- DATA write with TimeoutCycles = 0: waits indefinitely, no error.

## Timing
- Minimum access: req_i sampled at T; ACCESS at T+1; ready_o at T+2.
- The earliest next request is accepted at T+3.
- DATA write with tx_ready_i low: ready_o arrives 1 cycle after the cycle in which tx_ready_i is seen high. tx_valid_o stays high and stable every ACCESS cycle until accepted or timed out.
- rx_pop_o and the rdata capture occur in the same ACCESS cycle (T+1).
- All outputs are registered or decoded from state only; no combinational path from req_i.
- Reset values: state IDLE; ready_o, err_o, tx_valid_o, rx_pop_o, irq_o = 0; rdata_o = 0; tx_data_o = 0; baud_sel_o = 0; CTRL = 0; sticky flags = 0; counter = 0.
- Reset asserted mid-access: the bridge aborts immediately, no response is issued, and tx_valid_o drops asynchronously.

## Configuration
- UART_BRIDGE_IRQ_EN defined:
  - irq_o = (rx_ie & rx_valid_i) | (tx_ie & tx_ready_i) | (err_ie & (overrun | tx_timeout)), registered, so 1-cycle delay.
- UART_BRIDGE_IRQ_EN undefined:
  - irq_o tied 0.
  - CTRL[4:2] read 0 and writes to them are ignored.
  - Sticky flags and STATUS are unchanged.

## Structure
- Shared package uart_pkg holds:
  - register offset localparams (DATA, STATUS, CTRL);
  - STATUS/CTRL bit index constants;
  - the bridge state enum;
  - a packed ctrl_reg_t struct.
- No sub-module is natural: FSM, register file and counter are a single module.

## Test plan
- Write 0x41 to DATA with tx_ready_i high: tx_valid_o = 1 with tx_data_o = 0x41 at T+1; ready_o = 1 and err_o = 0 at T+2.
- Write to DATA with tx_ready_i low, TimeoutCycles = 8: tx_valid_o high for 8 cycles, then ready_o = 1, err_o = 1, and STATUS reads 0x8 (+ bit1 if ready).
- Read DATA with rx_valid_i = 1, rx_data_i = 0x5A: rdata_o = 0x0000005A and one rx_pop_o pulse. Read again empty: rdata_o = 0x80000000, no pop.
- Pulse rx_overrun_i in the same cycle as a STATUS write of 0x4: bit2 remains set. A later write of 0x4 clears it.
- Write CTRL = 0x06 with rx_valid_i = 1, macro defined: baud_sel_o = 2, irq_o = 1. Macro undefined: irq_o = 0 and CTRL reads 0x02.
- Access 0xC or 0x2: err_o = 1, rdata_o = 0, no tx_valid_o, no rx_pop_o. Assert rst_ni low during a TX wait: all outputs return to 0 immediately.
